count_checker: RTL and testbench

COUNT_CHECKER -- requirements
Module: count_checker

---
 rtl/count_pkg.sv | 14 +
 rtl/sat_counter.sv | 26 ++
 rtl/count_checker.sv | 145 ++++++++++++++
 tb/tb_count_checker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// count_pkg: shared state encoding and default parameters for count_checker.
package count_pkg;

  localparam int unsigned DEF_WIDTH    = 4;
  localparam int unsigned DEF_LOCK_CNT = 2;
  localparam int unsigned DEF_ERR_W    = 8;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter; sticks at all-ones, never wraps.
module sat_counter
  import count_pkg::*;
#(
  parameter int unsigned ERR_W = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [ERR_W-1:0] value
);

  logic [ERR_W-1:0] r_value;

  // count each inc pulse until the counter is full
  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
    end else if (inc && (r_value != '1)) begin
      r_value <= r_value + ERR_W'(1);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/count_checker.sv
// count_checker: watches a free-running up-counter value (qd), locks onto a
// valid +1 sequence and flags breaks (err), correct wraps (wrap) and keeps a
// saturating violation total (err_cnt).
// Optional feature macro: COUNT_CHECKER_CAPTURE_EN adds exp_val/got_val,
// which hold the expected and observed values of the most recent error.
module count_checker
  import count_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned ERR_W    = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] qd,
  input  logic             dut_reset,
  output logic             locked,
  output logic             err,
  output logic             wrap,
`ifdef COUNT_CHECKER_CAPTURE_EN
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] exp_val,
  output logic [WIDTH-1:0] got_val
`else
  output logic [ERR_W-1:0] err_cnt
`endif
);

  localparam logic [3:0] LOCK_GOOD = LOCK_CNT[3:0];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_prev_nxt;
  logic [WIDTH-1:0] w_expected;
  logic [3:0]       r_good;
  logic [3:0]       w_good_nxt;
  logic [3:0]       w_good_inc;
  logic             w_match;
  logic             w_err_nxt;
  logic             w_wrap_nxt;
  logic             r_err;
  logic             r_wrap;

  // expected next sample: +1 modulo 2^WIDTH (carry out discarded)
  assign w_expected = r_prev + WIDTH'(1);
  assign w_match    = (qd == w_expected);
  assign w_good_inc = r_good + 4'd1;

  // next-state / pulse decode; dut_reset overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_good_nxt  = r_good;
    w_err_nxt   = 1'b0;
    w_wrap_nxt  = 1'b0;
    if (dut_reset) begin
      w_state_nxt = SEARCH;
      w_good_nxt  = '0;
    end else begin
      case (r_state)
        SEARCH: begin
          w_prev_nxt  = qd;
          w_good_nxt  = '0;
          w_state_nxt = ACQUIRE;
        end
        ACQUIRE: begin
          w_prev_nxt = qd;
          if (w_match) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == LOCK_GOOD) begin
              w_state_nxt = LOCKED;
            end
          end else begin
            w_good_nxt = '0;
          end
        end
        LOCKED: begin
          w_prev_nxt = qd;
          if (w_match) begin
            w_wrap_nxt = (r_prev == '1) && (qd == '0);
          end else begin
            w_err_nxt   = 1'b1;
            w_good_nxt  = '0;
            w_state_nxt = ACQUIRE;
          end
        end
        default: begin
          w_state_nxt = SEARCH;
          w_good_nxt  = '0;
        end
      endcase
    end
  end

  // state and registered pulse outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEARCH;
      r_prev  <= '0;
      r_good  <= '0;
      r_err   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_prev_nxt;
      r_good  <= w_good_nxt;
      r_err   <= w_err_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign locked = (r_state == LOCKED);
  assign err    = r_err;
  assign wrap   = r_wrap;

  sat_counter #(
    .ERR_W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (w_err_nxt),
    .value(err_cnt)
  );

`ifdef COUNT_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] r_exp_val;
  logic [WIDTH-1:0] r_got_val;

  // snapshot expected/observed values on each error, hold until the next
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exp_val <= '0;
      r_got_val <= '0;
    end else if (w_err_nxt) begin
      r_exp_val <= w_expected;
      r_got_val <= qd;
    end
  end

  assign exp_val = r_exp_val;
  assign got_val = r_got_val;
`endif

endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: directed stimulus, behavioural reference model and a
// per-cycle compare process for count_checker (WIDTH=4, LOCK_CNT=2, ERR_W=8).
module tb_count_checker;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned LOCK_CNT = 2;
  localparam int unsigned ERR_W    = 8;
  localparam int          MOD      = 16;
  localparam int          SAT      = 255;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic [WIDTH-1:0] qd        = '0;
  logic             dut_reset = 1'b0;
  logic             locked;
  logic             err;
  logic             wrap;
  logic [ERR_W-1:0] err_cnt;
`ifdef COUNT_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] exp_val;
  logic [WIDTH-1:0] got_val;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  count_checker #(
    .WIDTH   (WIDTH),
    .LOCK_CNT(LOCK_CNT),
    .ERR_W   (ERR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .qd       (qd),
    .dut_reset(dut_reset),
    .locked   (locked),
    .err      (err),
    .wrap     (wrap),
`ifdef COUNT_CHECKER_CAPTURE_EN
    .err_cnt  (err_cnt),
    .exp_val  (exp_val),
    .got_val  (got_val)
`else
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: tracks the length of the current run of +1 steps.
  bit m_valid = 0;
  bit m_lk    = 0;
  int m_prev  = 0;
  int m_run   = 0;
  int m_cnt   = 0;
  bit m_err   = 0;
  bit m_wrap  = 0;
  int m_exp   = 0;
  int m_got   = 0;

  always @(posedge clk) begin
    bit ok;
    m_err  = 0;
    m_wrap = 0;
    if (reset) begin
      m_valid = 0; m_lk = 0; m_prev = 0; m_run = 0; m_cnt = 0;
      m_exp = 0; m_got = 0;
    end else if (dut_reset) begin
      m_valid = 0; m_lk = 0;
    end else if (!m_valid) begin
      m_valid = 1; m_run = 0; m_prev = int'(qd);
    end else begin
      ok = (int'(qd) == (m_prev + 1) % MOD);
      if (m_lk) begin
        if (ok) begin
          m_wrap = (m_prev == MOD - 1);
        end else begin
          m_err = 1;
          if (m_cnt < SAT) m_cnt++;
          m_exp = (m_prev + 1) % MOD;
          m_got = int'(qd);
          m_lk  = 0;
          m_run = 0;
        end
      end else begin
        m_run = ok ? m_run + 1 : 0;
        if (m_run >= int'(LOCK_CNT)) m_lk = 1;
      end
      m_prev = int'(qd);
    end
  end

  // compare DUT outputs against the model every cycle, away from the edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("locked",  int'(locked),  int'(m_lk));
      check("err",     int'(err),     int'(m_err));
      check("wrap",    int'(wrap),    int'(m_wrap));
      check("err_cnt", int'(err_cnt), m_cnt);
      check("err_wrap_excl", int'(err & wrap), 0);
`ifdef COUNT_CHECKER_CAPTURE_EN
      check("exp_val", int'(exp_val), m_exp);
      check("got_val", int'(got_val), m_got);
`endif
    end
  end

  // apply one sample; returns 1 time unit after the edge that took it
  task automatic cyc(input int q, input bit dr, input bit rs);
    qd        = WIDTH'(q);
    dut_reset = dr;
    reset     = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p;

    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk_en = 1'b1;
    check("rst_locked",  int'(locked),  0);
    check("rst_err",     int'(err),     0);
    check("rst_wrap",    int'(wrap),    0);
    check("rst_err_cnt", int'(err_cnt), 0);

    // free-running count: lock after two correct increments
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    check("lock_early", int'(locked), 0);
    cyc(2, 0, 0);
    check("lock_rise", int'(locked), 1);
    for (int v = 3; v < 16; v++) cyc(v, 0, 0);

    // wrap 15 -> 0 while locked
    cyc(0, 0, 0);
    check("wrap_pulse",  int'(wrap),   1);
    check("wrap_locked", int'(locked), 1);
    cyc(1, 0, 0);
    check("wrap_one_cycle", int'(wrap),    0);
    check("wrap_no_err",    int'(err_cnt), 0);

    // 5,6,7,9 break then relock on 10,11
    for (int v = 2; v < 8; v++) cyc(v, 0, 0);
    cyc(9, 0, 0);
    check("brk_err",     int'(err),     1);
    check("brk_err_cnt", int'(err_cnt), 1);
    check("brk_locked",  int'(locked),  0);
`ifdef COUNT_CHECKER_CAPTURE_EN
    check("brk_exp_val", int'(exp_val), 8);
    check("brk_got_val", int'(got_val), 9);
`endif
    cyc(10, 0, 0);
    check("brk_err_once", int'(err),    0);
    check("brk_unlocked", int'(locked), 0);
    cyc(11, 0, 0);
    check("relock", int'(locked), 1);

    // dut_reset for two cycles while locked
    cyc(12, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    check("dr_locked", int'(locked), 0);
    check("dr_err",    int'(err),    0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    check("dr_acq", int'(locked), 0);
    cyc(2, 0, 0);
    check("dr_relock", int'(locked),  1);
    check("dr_cnt",    int'(err_cnt), 1);

    // dut_reset masks what would be a mismatch while locked
    cyc(9, 1, 0);
    check("dr_mask_err", int'(err),     0);
    check("dr_mask_cnt", int'(err_cnt), 1);

    // mismatch during acquisition restarts the run without err
    cyc(4, 0, 0);
    cyc(5, 0, 0);
    cyc(9, 0, 0);
    check("acq_no_err", int'(err), 0);
    cyc(10, 0, 0);
    check("acq_restart", int'(locked), 0);
    cyc(11, 0, 0);
    check("acq_lock", int'(locked), 1);

    // checker reset while locked (also overrides dut_reset)
    cyc(3, 1, 1);
    check("mid_rst_locked",  int'(locked),  0);
    check("mid_rst_err",     int'(err),     0);
    check("mid_rst_wrap",    int'(wrap),    0);
    check("mid_rst_err_cnt", int'(err_cnt), 0);
`ifdef COUNT_CHECKER_CAPTURE_EN
    check("mid_rst_exp_val", int'(exp_val), 0);
    check("mid_rst_got_val", int'(got_val), 0);
`endif
    cyc(5, 0, 0);
    cyc(6, 0, 0);
    cyc(7, 0, 0);
    check("post_rst_lock", int'(locked), 1);
    cyc(9, 0, 0);
    check("post_rst_err_cnt", int'(err_cnt), 1);
`ifdef COUNT_CHECKER_CAPTURE_EN
    check("post_rst_exp_val", int'(exp_val), 8);
    check("post_rst_got_val", int'(got_val), 9);
`endif

    // saturation: 260 more injected breaks, each followed by a relock
    cyc(10, 0, 0);
    cyc(11, 0, 0);
    p = 11;
    for (int i = 0; i < 260; i++) begin
      cyc((p + 3) % MOD, 0, 0);
      cyc((p + 4) % MOD, 0, 0);
      cyc((p + 5) % MOD, 0, 0);
      p = (p + 5) % MOD;
    end
    check("sat_err_cnt", int'(err_cnt), 255);
    check("sat_locked",  int'(locked),  1);
    cyc((p + 3) % MOD, 0, 0);
    check("sat_err_pulse", int'(err),     1);
    check("sat_hold",      int'(err_cnt), 255);
    cyc((p + 4) % MOD, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
